pipe_frontend_ctrl: RTL

- Consumes the hazard unit's Stall/Flush outputs and applies them to the front of the 5-stage MIPS pipeline.
- Owns the PC register, the IF/ID register (instruction, PC+4, valid) and the ID/EX control-valid bit.
- Resolves redirects from branch-taken and jump, with a fixed priority against stall and flush.
- Keeps saturating event counters for stall cycles, bubbles and redirects, for debug and performance.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/sat_counter.sv | 27 ++
 rtl/pipe_frontend_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and redirect-select encoding for the pipeline front end.
package pipe_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'b00,
    SEL_BRANCH = 2'b01,
    SEL_JUMP   = 2'b10
  } redir_sel_e;

  // Branch wins over jump when both are decoded in the same cycle.
  function automatic redir_sel_e redir_sel(input logic pcsrc, input logic jump);
    if (pcsrc)     return SEL_BRANCH;
    else if (jump) return SEL_JUMP;
    else           return SEL_SEQ;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the front-end debug/performance events.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)                       count_d = '0;
    else if (inc && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_frontend_ctrl.sv
// Front-end control of the 5-stage pipeline: PC, IF/ID register, ID/EX valid
// bit and event counters, driven by the hazard unit's stall/flush.
module pipe_frontend_ctrl
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Stall,
  input  logic             Flush,
  input  logic             PCSrcD,
  input  logic             JumpD,
  input  logic [31:0]      PCBranchD,
  input  logic [31:0]      PCJumpD,
  input  logic [31:0]      InstrF,
  output logic [31:0]      PCF,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCPlus4D,
  output logic             ValidD,
  output logic             ValidE,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] BubbleCnt,
  output logic [CNT_W-1:0] RedirCnt
);

  logic [31:0] pcf_q, pcf_d;
  logic [31:0] instrd_q, instrd_d;
  logic [31:0] pcplus4d_q, pcplus4d_d;
  logic        validd_q, validd_d;
  logic        valide_q, valide_d;
  logic [31:0] pc_seq;
  redir_sel_e  sel;
  logic        stall_inc, bubble_inc, redir_inc;

  always_comb begin
    pcf_d      = pcf_q;
    instrd_d   = instrd_q;
    pcplus4d_d = pcplus4d_q;
    validd_d   = validd_q;
    pc_seq     = pcf_q + PC_INC;
    sel        = redir_sel(PCSrcD, JumpD);
    redir_inc  = 1'b0;

    // Under stall the ID operands are not ready, so redirects are held off;
    // the ID instruction re-presents them once the stall clears.
    if (!Stall) begin
      unique case (sel)
        SEL_BRANCH, SEL_JUMP: begin
          pcf_d      = (sel == SEL_BRANCH) ? PCBranchD : PCJumpD;
          instrd_d   = NOP_INSTR;
          pcplus4d_d = '0;
          validd_d   = 1'b0;
          redir_inc  = 1'b1;
        end
        default: begin
          pcf_d      = pc_seq;
          instrd_d   = InstrF;
          pcplus4d_d = pc_seq;
          validd_d   = 1'b1;
        end
      endcase
    end

    valide_d   = validd_q & ~Flush;
    stall_inc  = Stall;
    bubble_inc = Flush & validd_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pcf_q      <= RESET_PC;
      instrd_q   <= NOP_INSTR;
      pcplus4d_q <= '0;
      validd_q   <= 1'b0;
      valide_q   <= 1'b0;
    end else begin
      pcf_q      <= pcf_d;
      instrd_q   <= instrd_d;
      pcplus4d_q <= pcplus4d_d;
      validd_q   <= validd_d;
      valide_q   <= valide_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(CLK), .rst(RST), .inc(stall_inc), .clear(1'b0), .count(StallCnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk(CLK), .rst(RST), .inc(bubble_inc), .clear(1'b0), .count(BubbleCnt)
  );

  sat_counter #(.W(CNT_W)) u_redir_cnt (
    .clk(CLK), .rst(RST), .inc(redir_inc), .clear(1'b0), .count(RedirCnt)
  );

  assign PCF      = pcf_q;
  assign InstrD   = instrd_q;
  assign PCPlus4D = pcplus4d_q;
  assign ValidD   = validd_q;
  assign ValidE   = valide_q;

endmodule
